// File: rtl/dbg_entry_ctrl.sv
// dbg_entry_ctrl: debug-mode entry/exit sequencing with pipeline drain, dpc/cause capture
// and a single-cycle resume redirect back to dpc.
module dbg_entry_ctrl #(
   parameter int ADDR_WIDTH   = 32,
   parameter int FLUSH_CYCLES = 3
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rst,
   input  logic                  breakpoint,
   input  logic                  ebreak_ex,
   input  logic                  haltreq,
   input  logic                  resumereq,
   input  logic                  step,
   input  logic                  instr_retire,
   input  logic [ADDR_WIDTH-1:0] pc_ex,
   input  logic [ADDR_WIDTH-1:0] next_pc_ex,
   input  logic                  dpc_wr_en,
   input  logic [ADDR_WIDTH-1:0] dpc_wr_data,
   output logic                  dbg_mode,
   output logic                  halted,
   output logic                  resumeack,
   output logic                  pipe_flush,
   output logic                  resume_pc_valid,
   output logic [ADDR_WIDTH-1:0] resume_pc,
   output logic [ADDR_WIDTH-1:0] dpc,
   output logic [2:0]            dbg_cause
);
   typedef enum logic [1:0] {RUN, FLUSH, HALTED, RESUME} state_t;
   state_t     state;
   logic [3:0] cnt;
   logic       step_armed;
   logic       entry;
   logic       use_pc_ex;
   logic [2:0] cause;
   always_comb begin
      entry     = breakpoint | ebreak_ex | haltreq | (step_armed & instr_retire);
      use_pc_ex = breakpoint | ebreak_ex;
      cause     = breakpoint ? 3'd2 : ebreak_ex ? 3'd1 : haltreq ? 3'd3 : 3'd4;
   end
   assign resume_pc = dpc;
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state           <= RUN;
         cnt             <= '0;
         step_armed      <= 1'b0;
         dpc             <= '0;
         dbg_cause       <= '0;
         dbg_mode        <= 1'b0;
         halted          <= 1'b0;
         resumeack       <= 1'b0;
         pipe_flush      <= 1'b0;
         resume_pc_valid <= 1'b0;
      end else begin
         pipe_flush      <= 1'b0;
         resumeack       <= 1'b0;
         resume_pc_valid <= 1'b0;
         case (state)
            RUN: if (entry) begin
               state      <= FLUSH;
               cnt        <= 4'(FLUSH_CYCLES - 1);
               step_armed <= 1'b0;
               dpc        <= use_pc_ex ? pc_ex : next_pc_ex;
               dbg_cause  <= cause;
               dbg_mode   <= 1'b1;
               pipe_flush <= 1'b1;
            end
            FLUSH: if (cnt == 4'd0) begin
               state  <= HALTED;
               halted <= 1'b1;
            end else
               cnt <= cnt - 4'd1;
            HALTED: begin
               if (dpc_wr_en)
                  dpc <= dpc_wr_data;
               // haltreq wins over a simultaneous resumereq
               if (resumereq && !haltreq) begin
                  state           <= RESUME;
                  halted          <= 1'b0;
                  resumeack       <= 1'b1;
                  resume_pc_valid <= 1'b1;
               end
            end
            RESUME: begin
               state      <= RUN;
               dbg_mode   <= 1'b0;
               step_armed <= step;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_dbg_entry_ctrl.sv
// tb_dbg_entry_ctrl: directed vector table, hand sequence for reset during drain,
// and randomized stimulus against a timeline-based reference model.
module tb_dbg_entry_ctrl;
   localparam int AW = 32;
   localparam int FC = 3;
   logic          cpu_clk = 0, cpu_rst = 1;
   logic          breakpoint = 0, ebreak_ex = 0, haltreq = 0, resumereq = 0;
   logic          step = 0, instr_retire = 0, dpc_wr_en = 0;
   logic [AW-1:0] pc_ex = 0, next_pc_ex = 0, dpc_wr_data = 0;
   logic          dbg_mode, halted, resumeack, pipe_flush, resume_pc_valid;
   logic [AW-1:0] resume_pc, dpc;
   logic [2:0]    dbg_cause;
   int            checks = 0, errors = 0;
   int            since_entry;
   bit            m_halt, m_resume, m_step_armed;
   logic [AW-1:0] m_dpc;
   logic [2:0]    m_cause;
   typedef struct {
      logic [6:0]    in;
      logic [AW-1:0] pc, npc, wd;
      logic [3:0]    ex;
      logic [AW-1:0] edpc;
      logic [2:0]    ecause;
   } vec_t;
   vec_t tbl[$];

   dbg_entry_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .breakpoint(breakpoint), .ebreak_ex(ebreak_ex),
      .haltreq(haltreq), .resumereq(resumereq), .step(step), .instr_retire(instr_retire),
      .pc_ex(pc_ex), .next_pc_ex(next_pc_ex), .dpc_wr_en(dpc_wr_en), .dpc_wr_data(dpc_wr_data),
      .dbg_mode(dbg_mode), .halted(halted), .resumeack(resumeack), .pipe_flush(pipe_flush),
      .resume_pc_valid(resume_pc_valid), .resume_pc(resume_pc), .dpc(dpc), .dbg_cause(dbg_cause));

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(string n, logic [AW-1:0] a, logic [AW-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
      end
   endtask

   task model_reset();
      since_entry  = -1;
      m_halt       = 0;
      m_resume     = 0;
      m_step_armed = 0;
      m_dpc        = '0;
      m_cause      = '0;
   endtask

   // since_entry counts drain cycles elapsed after an entry event (-1 when not draining)
   task model_step();
      bit ev;
      ev = breakpoint | ebreak_ex | haltreq | (m_step_armed & instr_retire);
      if (m_resume) begin
         m_resume     = 0;
         m_step_armed = step;
      end else if (m_halt) begin
         if (dpc_wr_en) m_dpc = dpc_wr_data;
         if (resumereq && !haltreq) begin
            m_halt   = 0;
            m_resume = 1;
         end
      end else if (since_entry >= 0) begin
         if (since_entry == FC - 1) begin
            since_entry = -1;
            m_halt      = 1;
         end else since_entry++;
      end else if (ev) begin
         since_entry  = 0;
         m_step_armed = 0;
         m_cause      = breakpoint ? 3'd2 : ebreak_ex ? 3'd1 : haltreq ? 3'd3 : 3'd4;
         m_dpc        = (breakpoint || ebreak_ex) ? pc_ex : next_pc_ex;
      end
   endtask

   task cycle();
      model_step();
      @(posedge cpu_clk);
      #1;
      chk("m_dbg_mode", dbg_mode, since_entry >= 0 || m_halt || m_resume);
      chk("m_halted", halted, m_halt);
      chk("m_resumeack", resumeack, m_resume);
      chk("m_resume_pc_valid", resume_pc_valid, m_resume);
      chk("m_pipe_flush", pipe_flush, since_entry == 0);
      chk("m_dpc", dpc, m_dpc);
      chk("m_dbg_cause", dbg_cause, m_cause);
      if (m_resume) chk("m_resume_pc", resume_pc, m_dpc);
   endtask

   function automatic vec_t v(logic [6:0] in, logic [AW-1:0] pc, npc, wd,
                              logic [3:0] ex, logic [AW-1:0] edpc, logic [2:0] ec);
      vec_t r;
      r.in = in; r.pc = pc; r.npc = npc; r.wd = wd; r.ex = ex; r.edpc = edpc; r.ecause = ec;
      return r;
   endfunction

   task drive(logic [6:0] in, logic [AW-1:0] pc, npc, wd);
      {breakpoint, ebreak_ex, haltreq, resumereq, step, instr_retire, dpc_wr_en} = in;
      pc_ex = pc; next_pc_ex = npc; dpc_wr_data = wd;
   endtask

   initial begin
      // in = {bp, eb, hr, rr, st, ir, we}; ex = {dbg_mode, halted, resumeack, pipe_flush}
      tbl.push_back(v(7'b1000000, 'h100, 'h104, 0, 4'b1001, 'h100, 2));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h100, 2));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h100, 2));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1100, 'h100, 2));
      tbl.push_back(v(7'b0000001, 0, 0, 'h3000, 4'b1100, 'h3000, 2));
      tbl.push_back(v(7'b0001000, 0, 0, 0, 4'b1010, 'h3000, 2));
      tbl.push_back(v(7'b0001000, 0, 0, 0, 4'b0000, 'h3000, 2));
      tbl.push_back(v(7'b0010000, 'h200, 'h204, 0, 4'b1001, 'h204, 3));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h204, 3));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h204, 3));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1100, 'h204, 3));
      for (int i = 0; i < 4; i++) tbl.push_back(v(7'b0011000, 0, 0, 0, 4'b1100, 'h204, 3));
      tbl.push_back(v(7'b0011001, 0, 0, 'h400, 4'b1100, 'h400, 3));
      tbl.push_back(v(7'b0001000, 0, 0, 0, 4'b1010, 'h400, 3));
      tbl.push_back(v(7'b0000100, 0, 0, 0, 4'b0000, 'h400, 3));
      tbl.push_back(v(7'b0000100, 'h3f0, 'h3f4, 0, 4'b0000, 'h400, 3));
      tbl.push_back(v(7'b0000110, 'h400, 'h404, 0, 4'b1001, 'h404, 4));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h404, 4));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h404, 4));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1100, 'h404, 4));
      tbl.push_back(v(7'b0001000, 0, 0, 0, 4'b1010, 'h404, 4));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b0000, 'h404, 4));
      tbl.push_back(v(7'b1110000, 'h200, 'h204, 0, 4'b1001, 'h200, 2));
      tbl.push_back(v(7'b0000000, 0, 0, 0, 4'b1000, 'h200, 2));

      model_reset();
      repeat (2) @(posedge cpu_clk);
      #1;
      chk("rst_dbg_mode", dbg_mode, 0);
      chk("rst_halted", halted, 0);
      chk("rst_resumeack", resumeack, 0);
      chk("rst_pipe_flush", pipe_flush, 0);
      chk("rst_resume_pc_valid", resume_pc_valid, 0);
      chk("rst_dpc", dpc, 0);
      chk("rst_dbg_cause", dbg_cause, 0);
      cpu_rst = 0;

      foreach (tbl[i]) begin
         drive(tbl[i].in, tbl[i].pc, tbl[i].npc, tbl[i].wd);
         cycle();
         chk($sformatf("v%0d_dbg_mode", i), dbg_mode, tbl[i].ex[3]);
         chk($sformatf("v%0d_halted", i), halted, tbl[i].ex[2]);
         chk($sformatf("v%0d_resumeack", i), resumeack, tbl[i].ex[1]);
         chk($sformatf("v%0d_resume_pc_valid", i), resume_pc_valid, tbl[i].ex[1]);
         chk($sformatf("v%0d_pipe_flush", i), pipe_flush, tbl[i].ex[0]);
         chk($sformatf("v%0d_dpc", i), dpc, tbl[i].edpc);
         chk($sformatf("v%0d_dbg_cause", i), dbg_cause, tbl[i].ecause);
         if (tbl[i].ex[1]) chk($sformatf("v%0d_resume_pc", i), resume_pc, tbl[i].edpc);
      end

      // drain counter is at 1 here: async reset must clear everything without a clock edge
      drive(0, 0, 0, 0);
      #2 cpu_rst = 1;
      #1;
      chk("midflush_dbg_mode", dbg_mode, 0);
      chk("midflush_halted", halted, 0);
      chk("midflush_pipe_flush", pipe_flush, 0);
      chk("midflush_dpc", dpc, 0);
      chk("midflush_dbg_cause", dbg_cause, 0);
      model_reset();
      #2 cpu_rst = 0;
      drive(7'b1000000, 'h500, 'h504, 0);
      cycle();
      chk("post_rst_pipe_flush", pipe_flush, 1);
      chk("post_rst_dpc", dpc, 'h500);
      chk("post_rst_dbg_cause", dbg_cause, 2);
      drive(0, 0, 0, 0);
      repeat (FC) cycle();
      chk("post_rst_halted", halted, 1);

      for (int n = 0; n < 3000; n++) begin
         breakpoint   = ($urandom_range(0, 9) == 0);
         ebreak_ex    = ($urandom_range(0, 9) == 0);
         haltreq      = ($urandom_range(0, 5) == 0);
         resumereq    = ($urandom_range(0, 2) == 0);
         step         = $urandom_range(0, 1);
         instr_retire = $urandom_range(0, 1);
         dpc_wr_en    = ($urandom_range(0, 3) == 0);
         pc_ex        = $urandom;
         next_pc_ex   = $urandom;
         dpc_wr_data  = $urandom;
         if ($urandom_range(0, 299) == 0) begin
            #2 cpu_rst = 1;
            #2 cpu_rst = 0;
            model_reset();
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
